// File: rtl/ic_ne_bvashr_sweep_pkg.sv
// Shared types for the invertibility-condition sweep block: the FSM state
// encoding and the number of operands expected to satisfy the condition.
package ic_ne_bvashr_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Every W-bit value except all-zeros and all-ones satisfies the condition.
  function automatic int unsigned expected_count(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/ic_ne_bvashr_eval.sv
// Combinational invertibility predicate: operand is neither all-zeros nor
// all-ones.
module ic_ne_bvashr_eval #(
  parameter int W = 8
) (
  input  logic [W-1:0] operand,
  output logic         ic
);

  assign ic = (|operand) && !(&operand);

endmodule

// File: rtl/ic_ne_bvashr_sweep.sv
// Invertibility-condition evaluator with a stream path and an exhaustive
// self-sweep of all 2^W operands behind a single-entry output register.
module ic_ne_bvashr_sweep
  import ic_ne_bvashr_sweep_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ic,
  output logic         out_src,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W:0]   true_count
);

  localparam logic [W:0] EXP_CNT = (W+1)'(expected_count(W));

  state_t       state;
  logic [W-1:0] cnt;
  logic         slot_free;
  logic         ld_stream;
  logic         ld_sweep;
  logic [W-1:0] data_p0;
  logic         src_p0;
  logic         ic_p0;

  // Stage 0: select the operand for the output register and evaluate it
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst_n && (state == IDLE) && !start && slot_free;
  assign ld_stream = in_valid && in_ready;
  assign ld_sweep  = (state == SWEEP) && slot_free;
  assign data_p0   = ld_sweep ? cnt : in_data;
  assign src_p0    = ld_sweep;
  assign busy      = (state == SWEEP) || (state == DRAIN);

  ic_ne_bvashr_eval #(.W(W)) u_eval (
    .operand (data_p0),
    .ic      (ic_p0)
  );

  // Stage 1: output register, sweep control and verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ic     <= 1'b0;
      out_src    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      true_count <= '0;
    end else begin
      done <= 1'b0;

      if (ld_sweep || ld_stream) begin
        out_valid <= 1'b1;
        out_data  <= data_p0;
        out_ic    <= ic_p0;
        out_src   <= src_p0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && out_src && out_ic)
        true_count <= true_count + (W+1)'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state      <= SWEEP;
            cnt        <= '0;
            true_count <= '0;
            pass       <= 1'b0;
          end
        end
        SWEEP: begin
          // The final value parks cnt at all-ones instead of wrapping.
          if (ld_sweep) begin
            if (&cnt) state <= DRAIN;
            else      cnt   <= cnt + W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (true_count == EXP_CNT);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_ne_bvashr_sweep.sv
// Randomized bench for ic_ne_bvashr_sweep: a transaction-level model predicts
// every output each cycle, plus hand-computed literal expectations.
module tb_ic_ne_bvashr_sweep;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_SWEEP = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ic;
  logic         out_src;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W:0]   true_count;

  logic         start1;
  logic         in_valid1;
  logic         in_ready1;
  logic [0:0]   in_data1;
  logic         out_valid1;
  logic         out_ready1;
  logic [0:0]   out_data1;
  logic         out_ic1;
  logic         out_src1;
  logic         busy1;
  logic         done1;
  logic         pass1;
  logic [1:0]   true_count1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ic_ne_bvashr_sweep #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ic     (out_ic),
    .out_src    (out_src),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .true_count (true_count)
  );

  ic_ne_bvashr_sweep #(.W(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_data    (in_data1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_data   (out_data1),
    .out_ic     (out_ic1),
    .out_src    (out_src1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .true_count (true_count1)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_ic(input int v, input int w);
    return (v != 0) && (v != (1 << w) - 1);
  endfunction

  // Behavioural model: q holds what the output register should contain.
  typedef struct {
    int d;
    bit src;
  } exp_t;

  exp_t q[$];
  exp_t it;
  int   mode  = M_IDLE;
  int   nv    = 0;
  int   tc    = 0;
  int   dcnt  = 0;
  bit   mpass = 1'b0;
  bit   armed = 1'b0;
  bit   ir_exp;
  bit   slot;
  int   m0;

  always @(negedge clk) begin
    ir_exp = rst_n && (mode == M_IDLE) && !start && (q.size() == 0 || out_ready);
    if (armed) begin
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_ic", out_ic, ref_ic(q[0].d, W));
        chk("out_src", out_src, q[0].src);
      end
      chk("busy", busy, (mode == M_SWEEP) || (mode == M_DRAIN));
      chk("done", done, dcnt == 1);
      chk("true_count", true_count, tc);
      chk("pass", pass, mpass);
      chk("in_ready", in_ready, ir_exp);
    end
    if (!rst_n) begin
      q.delete();
      mode  = M_IDLE;
      nv    = 0;
      tc    = 0;
      dcnt  = 0;
      mpass = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      m0   = mode;
      slot = (q.size() == 0) || out_ready;
      if (dcnt == 2) begin
        dcnt  = 1;
        mode  = M_IDLE;
        mpass = (tc == MAXV - 1);
      end else if (dcnt == 1) begin
        dcnt = 0;
      end
      if (q.size() != 0 && out_ready) begin
        it = q.pop_front();
        if (it.src && ref_ic(it.d, W)) tc++;
        if (it.src && it.d == MAXV) begin
          mode = M_DONE;
          dcnt = 2;
        end
      end
      if (m0 == M_IDLE) begin
        if (start) begin
          mode  = M_SWEEP;
          nv    = 0;
          tc    = 0;
          mpass = 1'b0;
        end else if (in_valid && ir_exp) begin
          q.push_back('{d: int'(in_data), src: 1'b0});
        end
      end else if (m0 == M_SWEEP && slot) begin
        q.push_back('{d: nv, src: 1'b1});
        if (nv == MAXV) mode = M_DRAIN;
        else nv++;
      end
    end
  end

  int n;
  logic [W-1:0] vecs [4];
  bit           ics  [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    vecs[0] = 8'h00; vecs[1] = 8'hFF; vecs[2] = 8'h01; vecs[3] = 8'h80;
    ics[0] = 1'b0; ics[1] = 1'b0; ics[2] = 1'b1; ics[3] = 1'b1;

    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_true_count", true_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Directed stream operands with literal predicate results.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i];
      #1;
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_lit_data", out_data, vecs[i]);
      chk("stream_lit_ic", out_ic, ics[i]);
      chk("stream_lit_src", out_src, 0);
    end
    in_valid = 1'b0;

    // Random stream traffic with backpressure.
    for (int i = 0; i < 200; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    // Full-rate sweep: done 258 cycles after the start edge.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    chk("sweep_done_latency", n, 258);
    chk("sweep_lit_count", true_count, 254);
    chk("sweep_lit_pass", pass, 1);
    step();
    chk("done_one_cycle", done, 0);

    // Start wins over in_valid; then a sweep under random backpressure.
    in_valid = 1'b1;
    in_data  = 8'h55;
    start    = 1'b1;
    #1;
    chk("start_blocks_in_ready", in_ready, 0);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 3000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = W'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      step();
      n++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sweep_done_seen", done, 1);
    chk("bp_sweep_count", true_count, 254);
    chk("bp_sweep_pass", pass, 1);
    step();

    // Reset in the middle of a sweep.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (101) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ic", out_ic, 0);
    chk("midrst_out_src", out_src, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_count", true_count, 0);
    rst_n = 1'b1;
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      out_ready = ($urandom_range(0, 1) != 0);
      step();
      n++;
    end
    out_ready = 1'b1;
    chk("post_rst_done_seen", done, 1);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_count", true_count, 254);
    step();

    // W=1 sweep on the second instance.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("w1_r0_valid", out_valid1, 1);
    chk("w1_r0_data", out_data1, 0);
    chk("w1_r0_ic", out_ic1, 0);
    chk("w1_r0_src", out_src1, 1);
    step();
    chk("w1_r1_data", out_data1, 1);
    chk("w1_r1_ic", out_ic1, 0);
    step();
    chk("w1_no_early_done", done1, 0);
    step();
    chk("w1_done", done1, 1);
    chk("w1_count", true_count1, 0);
    chk("w1_pass", pass1, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_ne_bvashr_sweep.md
IC_NE_BVASHR_SWEEP -- requirements
Module: ic_ne_bvashr_sweep

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 in_valid  input  1  stream operand valid.
REQ-006 in_ready  output  1  stream operand accepted when in_valid && in_ready.
REQ-007 in_data  input  W  stream operand.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result when out_valid && out_ready.
REQ-010 out_data  output  W  operand the result belongs to.
REQ-011 out_ic  output  1  invertibility condition: 1 iff operand is neither all-zeros nor all-ones.
REQ-012 out_src  output  1  0 = stream operand, 1 = sweep-generated operand.
REQ-013 busy  output  1  high in SWEEP and DRAIN.
REQ-014 done  output  1  single-cycle pulse at sweep completion.
REQ-015 pass  output  1  sweep verdict, held until next accepted start.
REQ-016 true_count  output  W+1  number of sweep results with out_ic=1, held until next accepted start.

Function
REQ-017 out_ic = NOT(all bits 0) AND NOT(all bits 1) of the operand, evaluated combinationally, registered into the output stage.
REQ-018 Single-entry output register; latency exactly 1 cycle from accept (stream) or generation (sweep) to out_valid.
REQ-019 While out_valid && !out_ready, out_data/out_ic/out_src hold stable.
REQ-020 Output stage loads when empty or draining (out_valid=0 or out_ready=1) in the same cycle; full throughput 1 result/cycle.
REQ-021 FSM states: IDLE, SWEEP, DRAIN, DONE.
REQ-022 IDLE: in_ready = !start && (!out_valid || out_ready); stream operands pass through with out_src=0.
REQ-023 IDLE with start=1: go SWEEP, clear counter cnt, true_count, pass; start wins over simultaneous in_valid (operand not accepted).
REQ-024 start outside IDLE is ignored; in_ready=0 outside IDLE.
REQ-025 SWEEP: each cycle the output stage can load, load cnt with out_src=1 and increment cnt; cnt runs 0..2^W-1 in order, no value skipped or repeated under backpressure.
REQ-026 SWEEP: on loading cnt = 2^W-1, go DRAIN (no wrap-around of cnt).
REQ-027 DRAIN: stay until the last sweep result is handshaken, then go DONE.
REQ-028 true_count increments by 1 on each sweep-result handshake with out_ic=1; stream results never change it.
REQ-029 DONE: done=1 for exactly one cycle, pass = (true_count == 2^W-2), then IDLE.
REQ-030 W=1: expected count 0; sweep of 2 values yields true_count=0, pass=1.

Reset
REQ-031 rst_n=0 at a clock edge: state IDLE, out_valid=0, out_data=0, out_ic=0, out_src=0, busy=0, done=0, pass=0, true_count=0, cnt=0.
REQ-032 Reset mid-sweep aborts it; no done pulse; in-flight result discarded.
REQ-033 in_ready=0 while rst_n=0.

Structure
REQ-034 Shared package holds the FSM state enum and a function returning expected count 2^W-2 for a given W.
REQ-035 Predicate implemented in one combinational sub-module ic_ne_bvashr_eval (parameter W, input operand, output ic), instantiated once on the output-stage input mux.

Verification
REQ-036 W=8, stream 0x00, 0xFF, 0x01, 0x80, out_ready=1 -> out_ic 0,0,1,1 one cycle after each accept, out_src=0.
REQ-037 W=8, start with out_ready=1 -> 256 consecutive results 0x00..0xFF, done pulse 258 cycles after start, true_count=254, pass=1.
REQ-038 W=8 sweep with out_ready toggled randomly -> every value 0..255 exactly once in order, true_count=254, pass=1.
REQ-039 start and in_valid in same IDLE cycle -> operand not accepted, sweep begins, in_ready=0 until IDLE.
REQ-040 rst_n=0 after 100 sweep results -> all outputs reset per REQ-031, no done; next start gives full sweep, pass=1.
REQ-041 W=1 sweep -> results 0,1 both out_ic=0, true_count=0, pass=1.
